// File: rtl/core_mem_reader_pkg.sv
// Shared types and constants for the core-memory reader and its response FIFO.
package core_mem_reader_pkg;

    localparam int BEAT_BYTES = 16;

    localparam int DEF_DATA_WIDTH      = 128;
    localparam int DEF_ADDR_WIDTH      = 26;
    localparam int DEF_LEN_WIDTH       = 16;
    localparam int DEF_MAX_OUTSTANDING = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/core_mem_reader_if.sv
// Bus bundle for core_mem_reader: request port, DMA command/response ports and AXI-Stream output.
interface core_mem_reader_if
    import core_mem_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [LEN_WIDTH-1:0]    req_len;
    logic                    req_valid;
    logic                    req_ready;

    logic                    dma_cmd_rd_en;
    logic [ADDR_WIDTH-1:0]   dma_cmd_rd_addr;
    logic                    dma_cmd_rd_last;
    logic                    dma_cmd_rd_ready;

    logic                    dma_rd_resp_valid;
    logic                    dma_rd_resp_ready;
    logic [DATA_WIDTH-1:0]   dma_rd_resp_data;

    logic [DATA_WIDTH-1:0]   m_axis_tdata;
    logic [DATA_WIDTH/8-1:0] m_axis_tkeep;
    logic                    m_axis_tvalid;
    logic                    m_axis_tlast;
    logic                    m_axis_tready;

    // master is the reader itself; slave is the requester/DMA/stream sink side
    modport master (
        input  req_addr, req_len, req_valid,
        output req_ready,
        output dma_cmd_rd_en, dma_cmd_rd_addr, dma_cmd_rd_last,
        input  dma_cmd_rd_ready,
        input  dma_rd_resp_valid, dma_rd_resp_data,
        output dma_rd_resp_ready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        output req_addr, req_len, req_valid,
        input  req_ready,
        input  dma_cmd_rd_en, dma_cmd_rd_addr, dma_cmd_rd_last,
        output dma_cmd_rd_ready,
        output dma_rd_resp_valid, dma_rd_resp_data,
        input  dma_rd_resp_ready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );

endinterface

// File: rtl/core_rd_resp_fifo.sv
// Response buffer: synchronous FIFO with a registered output stage; DEPTH must be a power of 2, >= 2.
module core_rd_resp_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic w_load;
    logic w_mem_pop;
    logic w_bypass;
    logic w_mem_push;

    // an empty output stage refills from memory first, otherwise straight from the input
    assign w_load     = !r_out_valid || i_ready;
    assign w_mem_pop  = w_load && (r_count != '0);
    assign w_bypass   = w_load && (r_count == '0) && i_push;
    assign w_mem_push = i_push && !w_bypass && (r_count != CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (w_mem_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_mem_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_mem_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_mem_push, w_mem_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                if (w_mem_pop) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_mem[r_rd_ptr];
                end else if (i_push) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= i_data;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule

// File: rtl/core_mem_reader.sv
// Splits (addr, len) requests into 16-byte DMA beat reads and streams the responses out on AXI-Stream.
// Define CORE_MEM_READER_STALL_CNT_EN to build the output back-pressure counter behind stall_cycles.
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   ISSUE | issuing beat read commands, throttled by outstanding beats
//   DRAIN | last command issued, streaming the remaining beats
module core_mem_reader
    import core_mem_reader_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic              clk,
    input  logic              rst_n,
    core_mem_reader_if.master bus,
    output logic              busy,
    output logic [31:0]       stall_cycles
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int LSB_W  = $clog2(BEAT_BYTES);
    localparam int BEAT_W = LEN_WIDTH + 1 - LSB_W;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING) + 1;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BEAT_W-1:0]     r_cmd_left;
    logic [BEAT_W-1:0]     r_beat_left;
    logic [KEEP_W-1:0]     r_keep_last;
    logic [OUT_W-1:0]      r_outstanding;
    logic [OUT_W-1:0]      r_pending;

    logic                  w_req_hs;
    logic                  w_req_go;
    logic                  w_cmd_hs;
    logic                  w_str_hs;
    logic                  w_resp_acc;
    logic [LEN_WIDTH:0]    w_len_ext;
    logic [BEAT_W-1:0]     w_beats;
    logic [LSB_W-1:0]      w_len_mod;
    logic [KEEP_W-1:0]     w_keep_req;
    logic                  w_fifo_valid;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_last_beat;
    logic                  w_unused;

    assign w_unused = ^bus.req_addr[LSB_W-1:0];

    assign w_req_hs   = bus.req_valid && bus.req_ready;
    assign w_req_go   = w_req_hs && (bus.req_len != '0);
    assign w_cmd_hs   = bus.dma_cmd_rd_en && bus.dma_cmd_rd_ready;
    assign w_str_hs   = bus.m_axis_tvalid && bus.m_axis_tready;
    // responses with no command in flight (e.g. from an abandoned request) are dropped
    assign w_resp_acc = bus.dma_rd_resp_valid && bus.dma_rd_resp_ready && (r_pending != '0);

    assign w_len_ext = {1'b0, bus.req_len} + (LEN_WIDTH + 1)'(BEAT_BYTES - 1);
    assign w_beats   = w_len_ext[LEN_WIDTH:LSB_W];
    assign w_len_mod = bus.req_len[LSB_W-1:0];

    always_comb begin
        w_keep_req = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            w_keep_req[i] = (w_len_mod == '0) || (i < int'(w_len_mod));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_go) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_cmd_hs && bus.dma_cmd_rd_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_str_hs && bus.m_axis_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready         = (r_state == ST_IDLE);
    assign bus.dma_cmd_rd_en     = (r_state == ST_ISSUE) && (r_outstanding < OUT_W'(MAX_OUTSTANDING));
    assign bus.dma_cmd_rd_addr   = r_addr;
    assign bus.dma_cmd_rd_last   = (r_state == ST_ISSUE) && (r_cmd_left == BEAT_W'(1));
    assign bus.dma_rd_resp_ready = rst_n;
    assign busy                  = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_cmd_left    <= '0;
            r_beat_left   <= '0;
            r_keep_last   <= '0;
            r_outstanding <= '0;
            r_pending     <= '0;
        end else begin
            if (w_req_go) begin
                r_addr      <= {bus.req_addr[ADDR_WIDTH-1:LSB_W], LSB_W'(0)};
                r_cmd_left  <= w_beats;
                r_beat_left <= w_beats;
                r_keep_last <= w_keep_req;
            end else begin
                if (w_cmd_hs) begin
                    r_addr     <= r_addr + ADDR_WIDTH'(BEAT_BYTES);
                    r_cmd_left <= r_cmd_left - BEAT_W'(1);
                end
                if (w_str_hs) begin
                    r_beat_left <= r_beat_left - BEAT_W'(1);
                end
            end
            case ({w_cmd_hs, w_str_hs})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            case ({w_cmd_hs, w_resp_acc})
                2'b10:   r_pending <= r_pending + OUT_W'(1);
                2'b01:   r_pending <= r_pending - OUT_W'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    // outstanding never exceeds DEPTH, so the FIFO cannot overflow
    core_rd_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_resp_acc),
        .i_data  (bus.dma_rd_resp_data),
        .i_ready (bus.m_axis_tready),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_data)
    );

    assign w_last_beat       = (r_beat_left == BEAT_W'(1));
    assign bus.m_axis_tvalid = w_fifo_valid;
    assign bus.m_axis_tdata  = w_fifo_data;
    assign bus.m_axis_tlast  = w_fifo_valid && w_last_beat;
    assign bus.m_axis_tkeep  = !w_fifo_valid ? '0 : (w_last_beat ? r_keep_last : '1);

`ifdef CORE_MEM_READER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (bus.m_axis_tvalid && !bus.m_axis_tready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_core_mem_reader.sv
// Directed bench for core_mem_reader: DMA responder model plus per-beat scoreboard of commands and stream beats.
module tb_core_mem_reader;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [31:0] stall_cycles;

    core_mem_reader_if #(.DATA_WIDTH(128), .ADDR_WIDTH(26), .LEN_WIDTH(16)) bus ();

    core_mem_reader #(
        .DATA_WIDTH      (128),
        .ADDR_WIDTH      (26),
        .LEN_WIDTH       (16),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [25:0]  dma_q [$];
    logic [127:0] exp_data_q [$];
    bit           dma_hold = 0;
    int           rdy_mode = 0;
    int           tr_mode  = 1;
    int           cyc_n    = 0;

    logic [25:0]  exp_base;
    int           exp_n, cmd_idx, beat_idx;
    logic [15:0]  exp_keep;
    int           outst, max_outst, stall_exp, tvalid_seen;

    bit           prev_cmd_wait, prev_str_wait;
    logic [25:0]  prev_addr;
    logic         prev_last, prev_tlast;
    logic [127:0] prev_data;
    logic [15:0]  prev_keep;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] beat_data(input logic [25:0] a);
        logic [31:0] w;
        w = {6'h0, a};
        return {w, ~w, w ^ 32'h5A5A_F00D, 32'hC0DE_0000 + w};
    endfunction

    task automatic drive();
        cyc_n++;
        bus.dma_cmd_rd_ready = (rdy_mode == 0) ? 1'b1 : ((cyc_n % 2) == 0);
        case (tr_mode)
            0:       bus.m_axis_tready = 1'b0;
            1:       bus.m_axis_tready = 1'b1;
            default: bus.m_axis_tready = ((cyc_n % 3) != 0);
        endcase
        if (!dma_hold && dma_q.size() > 0) begin
            bus.dma_rd_resp_valid = 1'b1;
            bus.dma_rd_resp_data  = beat_data(dma_q[0]);
        end else begin
            bus.dma_rd_resp_valid = 1'b0;
            bus.dma_rd_resp_data  = '0;
        end
    endtask

    // evaluates the handshakes that the coming rising edge will take
    task automatic monitor();
        logic cmd_hs, str_hs, exp_last;
        logic [127:0] e;
        cmd_hs = bus.dma_cmd_rd_en && bus.dma_cmd_rd_ready;
        str_hs = bus.m_axis_tvalid && bus.m_axis_tready;
        if (prev_cmd_wait) begin
            check_eq("cmd_hold_en", bus.dma_cmd_rd_en, 1'b1);
            check_eq("cmd_hold_addr", bus.dma_cmd_rd_addr, prev_addr);
            check_eq("cmd_hold_last", bus.dma_cmd_rd_last, prev_last);
        end
        if (prev_str_wait) begin
            check_eq("str_hold_valid", bus.m_axis_tvalid, 1'b1);
            check_eq("str_hold_data", bus.m_axis_tdata, prev_data);
            check_eq("str_hold_keep", bus.m_axis_tkeep, prev_keep);
            check_eq("str_hold_last", bus.m_axis_tlast, prev_tlast);
        end
        prev_cmd_wait = bus.dma_cmd_rd_en && !bus.dma_cmd_rd_ready;
        prev_addr     = bus.dma_cmd_rd_addr;
        prev_last     = bus.dma_cmd_rd_last;
        prev_str_wait = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_data     = bus.m_axis_tdata;
        prev_keep     = bus.m_axis_tkeep;
        prev_tlast    = bus.m_axis_tlast;

        if (bus.dma_rd_resp_valid && bus.dma_rd_resp_ready) void'(dma_q.pop_front());
        if (cmd_hs) begin
            check_eq("cmd_addr", bus.dma_cmd_rd_addr, exp_base + 26'(16 * cmd_idx));
            check_eq("cmd_last", bus.dma_cmd_rd_last, cmd_idx == exp_n - 1);
            dma_q.push_back(bus.dma_cmd_rd_addr);
            exp_data_q.push_back(beat_data(bus.dma_cmd_rd_addr));
            cmd_idx++;
            outst++;
        end
        if (str_hs) begin
            if (exp_data_q.size() == 0) begin
                check_eq("unexpected_beat", bus.m_axis_tvalid, 1'b0);
            end else begin
                e = exp_data_q.pop_front();
                exp_last = (beat_idx == exp_n - 1);
                check_eq("beat_data", bus.m_axis_tdata, e);
                check_eq("beat_tlast", bus.m_axis_tlast, exp_last);
                check_eq("beat_tkeep", bus.m_axis_tkeep, exp_last ? exp_keep : 16'hFFFF);
            end
            beat_idx++;
            outst--;
        end
        if (outst > max_outst) max_outst = outst;
        if (bus.m_axis_tvalid && !bus.m_axis_tready) stall_exp++;
        if (bus.m_axis_tvalid) tvalid_seen++;
    endtask

    task automatic cyc();
        drive();
        #1;
        monitor();
        @(negedge clk);
        #1;
    endtask

    task automatic check_stall(input string tag);
`ifdef CORE_MEM_READER_STALL_CNT_EN
        check_eq(tag, stall_cycles, stall_exp);
`else
        check_eq(tag, stall_cycles, 0);
`endif
    endtask

    task automatic do_req(input logic [25:0] addr, input logic [15:0] len);
        logic [16:0] t;
        exp_base  = {addr[25:4], 4'h0};
        exp_n     = (int'(len) + 15) / 16;
        t         = 17'(1) << len[3:0];
        exp_keep  = (len[3:0] == 4'h0) ? 16'hFFFF : (t[15:0] - 16'd1);
        cmd_idx   = 0;
        beat_idx  = 0;
        max_outst = 0;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.req_valid = 1'b1;
        check_eq("req_ready_idle", bus.req_ready, 1'b1);
        cyc();
        bus.req_valid = 1'b0;
        if (len != 0) check_eq("cmd_latency", bus.dma_cmd_rd_en, 1'b1);
        else          check_eq("zero_len_no_cmd", bus.dma_cmd_rd_en, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (beat_idx < exp_n && k < budget) begin
            cyc();
            k++;
        end
        check_eq("done_in_time", beat_idx, exp_n);
        check_eq("cmd_count", cmd_idx, exp_n);
        check_eq("idle_after_tlast", busy, 1'b0);
        check_eq("req_ready_after_tlast", bus.req_ready, 1'b1);
        check_stall("stall_cycles");
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_rd_en", bus.dma_cmd_rd_en, 1'b0);
        check_eq("rst_rd_addr", bus.dma_cmd_rd_addr, 0);
        check_eq("rst_rd_last", bus.dma_cmd_rd_last, 1'b0);
        check_eq("rst_tvalid", bus.m_axis_tvalid, 1'b0);
        check_eq("rst_tlast", bus.m_axis_tlast, 1'b0);
        check_eq("rst_tkeep", bus.m_axis_tkeep, 0);
        check_eq("rst_tdata", bus.m_axis_tdata, 0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_stall", stall_cycles, 0);
        check_eq("rst_resp_ready", bus.dma_rd_resp_ready, 1'b0);
    endtask

    task automatic clear_model();
        exp_data_q.delete();
        exp_n = 0; cmd_idx = 0; beat_idx = 0;
        outst = 0; max_outst = 0; stall_exp = 0; tvalid_seen = 0;
        prev_cmd_wait = 0; prev_str_wait = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst_n = 1'b0;
        bus.req_addr = '0; bus.req_len = '0; bus.req_valid = 1'b0;
        bus.dma_cmd_rd_ready = 1'b0; bus.dma_rd_resp_valid = 1'b0; bus.dma_rd_resp_data = '0;
        bus.m_axis_tready = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        #1;
        check_eq("rel_req_ready", bus.req_ready, 1'b1);
        check_eq("rel_resp_ready", bus.dma_rd_resp_ready, 1'b1);

        // 64 bytes at 0x100: four full beats
        rdy_mode = 0; tr_mode = 1;
        do_req(26'h100, 16'd64);
        wait_done(100);

        // 20 bytes: two beats, partial last keep
        do_req(26'h200, 16'd20);
        wait_done(100);

        // zero length: accepted, nothing issued
        do_req(26'h300, 16'd0);
        repeat (5) cyc();
        check_eq("zero_len_cmds", cmd_idx, 0);
        check_eq("zero_len_ready", bus.req_ready, 1'b1);
        check_eq("zero_len_busy", busy, 1'b0);

        // 256 bytes with stream stalled: throttled at 8 outstanding
        tr_mode = 0;
        do_req(26'h1000, 16'd256);
        repeat (30) cyc();
        check_eq("throttle_cmds", cmd_idx, 8);
        check_eq("throttle_rd_en", bus.dma_cmd_rd_en, 1'b0);
        check_eq("throttle_no_beats", beat_idx, 0);
        tr_mode = 1;
        wait_done(200);
        check_eq("max_outstanding", max_outst, 8);

        // toggling command ready and stream ready, unaligned address bits ignored
        rdy_mode = 1; tr_mode = 2;
        do_req(26'h2_000B, 16'd100);
        wait_done(200);
        check_eq("toggle_keep", exp_keep, 16'h000F);

        // reset after 3 of 10 commands, stray responses held back until after reset
        rdy_mode = 0; tr_mode = 0; dma_hold = 1;
        do_req(26'h4000, 16'd160);
        k = 0;
        while (cmd_idx < 3 && k < 50) begin
            cyc();
            k++;
        end
        check_eq("cmds_before_reset", cmd_idx, 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        clear_model();
        repeat (2) cyc();
        rst_n = 1'b1;
        #1;
        check_eq("rel2_req_ready", bus.req_ready, 1'b1);
        dma_hold = 0; tr_mode = 1;
        repeat (10) cyc();
        check_eq("strays_delivered", dma_q.size(), 0);
        check_eq("strays_dropped", tvalid_seen, 0);
        do_req(26'h5000, 16'd16);
        wait_done(100);
        check_eq("post_reset_beats", beat_idx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
